muskbus_arbiter: RTL and testbench

- N-port Muskbus arbiter/mux: grants one of NUM_PORTS bottom masters ownership of a single top Muskbus port.
- Generalised successor of the 2-port fixed-priority mux, adding:
  - selectable fixed-priority or round-robin arbitration
  - outstanding-response tracking, so ownership is never released while responses are in flight
  - an outstanding-request cap
  - a grant-time yield hint
- Sits between CPU-side agents (fetch, data, DMA) and the memory-side Muskbus.

---
 rtl/muskbus_arbiter_if.sv | 47 ++++
 rtl/muskbus_arbiter.sv | 149 ++++++++++++++
 tb/tb_muskbus_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/muskbus_arbiter_if.sv
// Muskbus arbiter signal bundle: per-port bottom signals, the shared top port and owner status.
interface muskbus_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    localparam int ID_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]            bot_bid;
    logic [NUM_PORTS-1:0]            bot_reqcyc;
    logic [NUM_PORTS*TAG_WIDTH-1:0]  bot_reqtag;
    logic [NUM_PORTS*DATA_WIDTH-1:0] bot_req;
    logic [NUM_PORTS-1:0]            bot_respack;
    logic [NUM_PORTS-1:0]            bot_reqack;
    logic [NUM_PORTS-1:0]            bot_respcyc;
    logic [NUM_PORTS*DATA_WIDTH-1:0] bot_resp;
    logic [NUM_PORTS-1:0]            bot_yield;

    logic                            top_bid;
    logic                            top_reqcyc;
    logic [TAG_WIDTH-1:0]            top_reqtag;
    logic [DATA_WIDTH-1:0]           top_req;
    logic                            top_respack;
    logic                            top_reqack;
    logic                            top_respcyc;
    logic [DATA_WIDTH-1:0]           top_resp;

    logic                            owner_valid;
    logic [ID_W-1:0]                 owner_id;

    // master: the bottom agents plus the upstream memory side; slave: the arbiter itself
    modport master (
        output bot_bid, bot_reqcyc, bot_reqtag, bot_req, bot_respack,
        output top_reqack, top_respcyc, top_resp,
        input  bot_reqack, bot_respcyc, bot_resp, bot_yield,
        input  top_bid, top_reqcyc, top_reqtag, top_req, top_respack,
        input  owner_valid, owner_id
    );

    modport slave (
        input  bot_bid, bot_reqcyc, bot_reqtag, bot_req, bot_respack,
        input  top_reqack, top_respcyc, top_resp,
        output bot_reqack, bot_respcyc, bot_resp, bot_yield,
        output top_bid, top_reqcyc, top_reqtag, top_req, top_respack,
        output owner_valid, owner_id
    );
endinterface

// File: rtl/muskbus_arbiter.sv
// N-port Muskbus arbiter: grants one bottom master ownership of the top port, fixed-priority or
// round-robin, holding ownership until every accepted request has been answered.
module muskbus_arbiter #(
    parameter int NUM_PORTS        = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int TAG_WIDTH        = 13,
    parameter int ARB_MODE         = 1,
    parameter int MAX_OUTSTANDING  = 8,
    parameter int MAX_GRANT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    muskbus_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_PORTS);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int GC_W  = (MAX_GRANT_CYCLES > 0) ? $clog2(MAX_GRANT_CYCLES + 1) : 1;
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [GC_W-1:0]  GC_MAX  = GC_W'(MAX_GRANT_CYCLES);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t            state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   rr_ptr;
    logic [OUT_W-1:0]  outstanding;
    logic [GC_W-1:0]   grant_cnt;

    logic [ID_W-1:0]       winner;
    logic [OUT_W-1:0]      out_next;
    logic [DATA_WIDTH-1:0] sel_req;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [NUM_PORTS-1:0]  own_mask;
    logic                  own_bid;
    logic                  own_reqcyc;
    logic                  own_respack;
    logic                  others_bid;
    logic                  req_cyc;
    logic                  req_acc;
    logic                  resp_ack;
    logic                  resp_acc;
    logic                  yield_now;
    logic                  active;

    // Scan from lowest to highest priority so the highest-priority bidder is written last
    always_comb begin
        int s;
        logic [ID_W-1:0] k;
        winner = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            s = (ARB_MODE != 0) ? int'(rr_ptr) + i : i;
            if (s >= NUM_PORTS) s = s - NUM_PORTS;
            k = ID_W'(s);
            if (bus.bot_bid[k]) winner = k;
        end
    end

    always_comb begin
        sel_req  = '0;
        sel_tag  = '0;
        own_mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (owner == ID_W'(i)) begin
                sel_req     = bus.bot_req[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tag     = bus.bot_reqtag[i*TAG_WIDTH +: TAG_WIDTH];
                own_mask[i] = 1'b1;
            end
        end
    end

    assign active      = (state != IDLE);
    assign own_bid     = bus.bot_bid[owner];
    assign own_reqcyc  = bus.bot_reqcyc[owner];
    assign own_respack = bus.bot_respack[owner];
    assign others_bid  = |(bus.bot_bid & ~own_mask);

    // Requests are masked at the outstanding cap and while draining
    assign req_cyc  = own_reqcyc && (state == BUSY) && (outstanding < OUT_MAX);
    assign req_acc  = req_cyc && bus.top_reqack;
    assign resp_ack = active && own_respack;
    assign resp_acc = resp_ack && bus.top_respcyc;

    assign yield_now = (MAX_GRANT_CYCLES > 0) && (grant_cnt == GC_MAX) &&
                       (state == BUSY) && others_bid;

    // A response with nothing outstanding is spurious and leaves the count at zero
    always_comb begin
        out_next = outstanding;
        if (req_acc && !resp_acc)
            out_next = outstanding + 1'b1;
        else if (!req_acc && resp_acc && (outstanding != '0))
            out_next = outstanding - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            outstanding <= '0;
            grant_cnt   <= '0;
        end else begin
            outstanding <= out_next;
            case (state)
                IDLE: begin
                    if (|bus.bot_bid) begin
                        state     <= BUSY;
                        owner     <= winner;
                        grant_cnt <= '0;
                        if (ARB_MODE != 0)
                            rr_ptr <= (winner == LAST_ID) ? '0 : winner + 1'b1;
                    end
                end
                BUSY: begin
                    if (grant_cnt != GC_MAX) grant_cnt <= grant_cnt + 1'b1;
                    if (!own_bid) state <= (out_next == '0) ? IDLE : DRAIN;
                end
                DRAIN: begin
                    if (own_bid)
                        state <= BUSY;
                    else if (out_next == '0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.bot_reqack  = '0;
        bus.bot_respcyc = '0;
        bus.bot_yield   = '0;
        if (active) begin
            bus.bot_reqack[owner]  = req_acc;
            bus.bot_respcyc[owner] = bus.top_respcyc;
            bus.bot_yield[owner]   = yield_now;
        end
    end

    assign bus.bot_resp    = {NUM_PORTS{bus.top_resp}};
    assign bus.top_bid     = active;
    assign bus.top_reqcyc  = req_cyc;
    assign bus.top_reqtag  = active ? sel_tag : '0;
    assign bus.top_req     = active ? sel_req : '0;
    assign bus.top_respack = resp_ack;
    assign bus.owner_valid = active;
    assign bus.owner_id    = owner;
endmodule

// File: tb/tb_muskbus_arbiter.sv
// Directed bench: round-robin instance (ifa) and fixed-priority/cap-2/yield-4 instance (ifb).
module tb_muskbus_arbiter;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    muskbus_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(64), .TAG_WIDTH(13)) ifa ();
    muskbus_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(64), .TAG_WIDTH(13)) ifb ();

    muskbus_arbiter #(
        .NUM_PORTS(4), .DATA_WIDTH(64), .TAG_WIDTH(13),
        .ARB_MODE(1), .MAX_OUTSTANDING(8), .MAX_GRANT_CYCLES(0)
    ) dut_rr (.clk(clk), .reset(reset), .bus(ifa));

    muskbus_arbiter #(
        .NUM_PORTS(4), .DATA_WIDTH(64), .TAG_WIDTH(13),
        .ARB_MODE(0), .MAX_OUTSTANDING(2), .MAX_GRANT_CYCLES(4)
    ) dut_fp (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        ifa.bot_bid = '0; ifa.bot_reqcyc = '0; ifa.bot_respack = '0;
        ifa.top_reqack = 1'b0; ifa.top_respcyc = 1'b0; ifa.top_resp = '0;
        ifb.bot_bid = '0; ifb.bot_reqcyc = '0; ifb.bot_respack = '0;
        ifb.top_reqack = 1'b0; ifb.top_respcyc = 1'b0; ifb.top_resp = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Bids held high through reset must not produce a grant
    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        ifa.bot_bid = 4'b1111;
        tick();
        tick();
        vectors++; if (ifa.owner_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_owner_valid: got %b expected 0", ifa.owner_valid); end
        vectors++; if (ifa.owner_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_owner_id: got %0d expected 0", ifa.owner_id); end
        vectors++; if (ifa.top_bid !== 1'b0 || ifa.top_reqcyc !== 1'b0 || ifa.top_respack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_top_ctrl: got bid=%b reqcyc=%b respack=%b expected 0", ifa.top_bid, ifa.top_reqcyc, ifa.top_respack); end
        vectors++; if (ifa.top_req !== 64'h0 || ifa.top_reqtag !== 13'h0) begin miscompares++; $display("[TB] FAIL reset_top_payload: got req=%h tag=%h expected 0", ifa.top_req, ifa.top_reqtag); end
        vectors++; if (ifa.bot_reqack !== 4'b0 || ifa.bot_respcyc !== 4'b0 || ifa.bot_yield !== 4'b0 || ifa.bot_resp !== '0) begin miscompares++; $display("[TB] FAIL reset_bot_outputs: got reqack=%b respcyc=%b yield=%b expected 0", ifa.bot_reqack, ifa.bot_respcyc, ifa.bot_yield); end
        vectors++; if (ifb.owner_valid !== 1'b0 || ifb.top_bid !== 1'b0 || ifb.bot_yield !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_fp_outputs: got valid=%b bid=%b yield=%b expected 0", ifb.owner_valid, ifb.top_bid, ifb.bot_yield); end
    endtask

    // All four bid from reset release; each owner holds 3 cycles then drops for one cycle
    task automatic test_round_robin();
        logic [1:0] exp_owner [5];
        exp_owner = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset = 1'b0;
        tick();
        for (int g = 0; g < 5; g++) begin
            vectors++; if (ifa.owner_valid !== 1'b1 || ifa.owner_id !== exp_owner[g]) begin miscompares++; $display("[TB] FAIL rr_owner_%0d: got valid=%b id=%0d expected valid=1 id=%0d", g, ifa.owner_valid, ifa.owner_id, exp_owner[g]); end
            tick();
            tick();
            ifa.bot_bid[exp_owner[g]] = 1'b0;
            tick();
            vectors++; if (ifa.owner_valid !== 1'b0 || ifa.top_bid !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_idle_gap_%0d: got valid=%b top_bid=%b expected 0", g, ifa.owner_valid, ifa.top_bid); end
            ifa.bot_bid = 4'b1111;
            tick();
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        ifb.bot_bid = 4'b0110;
        #1;
        vectors++; if (ifb.owner_valid !== 1'b0 || ifb.top_bid !== 1'b0) begin miscompares++; $display("[TB] FAIL fp_registered_grant: got valid=%b top_bid=%b expected 0", ifb.owner_valid, ifb.top_bid); end
        tick();
        vectors++; if (ifb.owner_valid !== 1'b1 || ifb.owner_id !== 2'd1 || ifb.top_bid !== 1'b1) begin miscompares++; $display("[TB] FAIL fp_first_grant: got valid=%b id=%0d bid=%b expected 1/1/1", ifb.owner_valid, ifb.owner_id, ifb.top_bid); end
        tick();
        tick();
        vectors++; if (ifb.owner_id !== 2'd1) begin miscompares++; $display("[TB] FAIL fp_hold: got id=%0d expected 1", ifb.owner_id); end
        ifb.bot_bid = 4'b0100;
        tick();
        vectors++; if (ifb.owner_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fp_release: got valid=%b expected 0", ifb.owner_valid); end
        tick();
        vectors++; if (ifb.owner_valid !== 1'b1 || ifb.owner_id !== 2'd2) begin miscompares++; $display("[TB] FAIL fp_second_grant: got valid=%b id=%0d expected 1/2", ifb.owner_valid, ifb.owner_id); end
    endtask

    task automatic test_drain();
        bit granted;
        do_reset();
        ifa.bot_bid = 4'b0100;
        tick();
        vectors++; if (ifa.owner_id !== 2'd2 || ifa.owner_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_grant: got valid=%b id=%0d expected 1/2", ifa.owner_valid, ifa.owner_id); end
        ifa.bot_bid = 4'b0101;
        ifa.bot_reqcyc = 4'b0100;
        ifa.top_reqack = 1'b1;
        #1;
        vectors++; if (ifa.top_req !== 64'hCCCC_0000_0000_0002 || ifa.top_reqtag !== 13'h1222) begin miscompares++; $display("[TB] FAIL drain_route_payload: got req=%h tag=%h expected cccc000000000002/1222", ifa.top_req, ifa.top_reqtag); end
        for (int r = 0; r < 3; r++) begin
            vectors++; if (ifa.top_reqcyc !== 1'b1 || ifa.bot_reqack !== 4'b0100) begin miscompares++; $display("[TB] FAIL drain_req_%0d: got reqcyc=%b reqack=%b expected 1/0100", r, ifa.top_reqcyc, ifa.bot_reqack); end
            tick();
        end
        ifa.bot_bid = 4'b0001;
        ifa.top_reqack = 1'b0;
        tick();
        vectors++; if (ifa.owner_valid !== 1'b1 || ifa.owner_id !== 2'd2 || ifa.top_bid !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_entered: got valid=%b id=%0d bid=%b expected 1/2/1", ifa.owner_valid, ifa.owner_id, ifa.top_bid); end
        vectors++; if (ifa.top_reqcyc !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_req_masked: got reqcyc=%b expected 0", ifa.top_reqcyc); end
        ifa.bot_reqcyc = 4'b0000;
        for (int r = 0; r < 3; r++) begin
            ifa.top_respcyc = 1'b1;
            ifa.bot_respack = 4'b0100;
            ifa.top_resp = 64'h5A5A_0000_0000_0010 + 64'(r);
            #1;
            vectors++; if (ifa.bot_respcyc !== 4'b0100 || ifa.top_respack !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_resp_%0d: got respcyc=%b respack=%b expected 0100/1", r, ifa.bot_respcyc, ifa.top_respack); end
            vectors++; if (ifa.bot_resp[2*64 +: 64] !== 64'h5A5A_0000_0000_0010 + 64'(r)) begin miscompares++; $display("[TB] FAIL drain_resp_data_%0d: got %h expected %h", r, ifa.bot_resp[2*64 +: 64], 64'h5A5A_0000_0000_0010 + 64'(r)); end
            tick();
            if (r < 2) begin
                vectors++; if (ifa.owner_valid !== 1'b1 || ifa.owner_id !== 2'd2) begin miscompares++; $display("[TB] FAIL drain_hold_%0d: got valid=%b id=%0d expected 1/2", r, ifa.owner_valid, ifa.owner_id); end
            end
        end
        ifa.top_respcyc = 1'b0;
        ifa.bot_respack = 4'b0000;
        granted = 1'b0;
        for (int c = 0; c < 4 && !granted; c++) begin
            if (ifa.owner_valid === 1'b1 && ifa.owner_id === 2'd0) granted = 1'b1;
            else tick();
        end
        vectors++; if (granted !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_port0_grant: got valid=%b id=%0d expected 1/0 within 4 cycles", ifa.owner_valid, ifa.owner_id); end
    endtask

    task automatic test_outstanding_cap();
        int pulses;
        do_reset();
        ifb.bot_bid = 4'b0001;
        tick();
        ifb.bot_reqcyc = 4'b0001;
        ifb.top_reqack = 1'b1;
        #1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (ifb.bot_reqack[0] === 1'b1) pulses++;
            tick();
        end
        vectors++; if (pulses != 2) begin miscompares++; $display("[TB] FAIL cap_pulses: got %0d expected 2", pulses); end
        vectors++; if (ifb.top_reqcyc !== 1'b0) begin miscompares++; $display("[TB] FAIL cap_masked: got reqcyc=%b expected 0", ifb.top_reqcyc); end
        ifb.top_respcyc = 1'b1;
        ifb.bot_respack = 4'b0001;
        #1;
        vectors++; if (ifb.top_respack !== 1'b1 || ifb.bot_reqack !== 4'b0) begin miscompares++; $display("[TB] FAIL cap_resp: got respack=%b reqack=%b expected 1/0000", ifb.top_respack, ifb.bot_reqack); end
        tick();
        // One slot free: accept and response coincide, so the count must not move
        vectors++; if (ifb.top_reqcyc !== 1'b1 || ifb.bot_reqack !== 4'b0001) begin miscompares++; $display("[TB] FAIL cap_slot_freed: got reqcyc=%b reqack=%b expected 1/0001", ifb.top_reqcyc, ifb.bot_reqack); end
        tick();
        ifb.top_respcyc = 1'b0;
        #1;
        vectors++; if (ifb.top_reqcyc !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_simultaneous: got reqcyc=%b expected 1", ifb.top_reqcyc); end
        tick();
        vectors++; if (ifb.top_reqcyc !== 1'b0) begin miscompares++; $display("[TB] FAIL cap_refilled: got reqcyc=%b expected 0", ifb.top_reqcyc); end
    endtask

    task automatic test_yield();
        logic [3:0] exp_y;
        do_reset();
        ifb.bot_bid = 4'b0010;
        tick();
        for (int gc = 0; gc < 8; gc++) begin
            if (gc == 2) ifb.bot_bid = 4'b1010;
            #1;
            exp_y = (gc >= 4) ? 4'b0010 : 4'b0000;
            vectors++; if (ifb.bot_yield !== exp_y || ifb.owner_id !== 2'd1) begin miscompares++; $display("[TB] FAIL yield_cycle_%0d: got yield=%b id=%0d expected %b/1", gc, ifb.bot_yield, ifb.owner_id, exp_y); end
            tick();
        end
        ifb.bot_bid = 4'b1000;
        tick();
        vectors++; if (ifb.bot_yield !== 4'b0 || ifb.owner_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL yield_release: got yield=%b valid=%b expected 0000/0", ifb.bot_yield, ifb.owner_valid); end
        tick();
        vectors++; if (ifb.owner_id !== 2'd3 || ifb.bot_yield !== 4'b0) begin miscompares++; $display("[TB] FAIL yield_next_owner: got id=%0d yield=%b expected 3/0000", ifb.owner_id, ifb.bot_yield); end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        ifa.bot_bid = 4'b0010;
        tick();
        ifa.bot_reqcyc = 4'b0010;
        ifa.top_reqack = 1'b1;
        tick();
        tick();
        ifa.bot_reqcyc = 4'b0000;
        ifa.top_reqack = 1'b0;
        ifa.bot_bid = 4'b0000;
        tick();
        vectors++; if (ifa.owner_valid !== 1'b1 || ifa.owner_id !== 2'd1) begin miscompares++; $display("[TB] FAIL rid_in_drain: got valid=%b id=%0d expected 1/1", ifa.owner_valid, ifa.owner_id); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (ifa.owner_valid !== 1'b0 || ifa.owner_id !== 2'd0 || ifa.top_bid !== 1'b0 || ifa.top_reqcyc !== 1'b0) begin miscompares++; $display("[TB] FAIL rid_outputs: got valid=%b id=%0d bid=%b reqcyc=%b expected 0", ifa.owner_valid, ifa.owner_id, ifa.top_bid, ifa.top_reqcyc); end
        ifa.top_respcyc = 1'b1;
        ifa.bot_respack = 4'b1111;
        ifa.top_resp = 64'h1234_5678_9ABC_DEF0;
        #1;
        vectors++; if (ifa.bot_respcyc !== 4'b0 || ifa.top_respack !== 1'b0) begin miscompares++; $display("[TB] FAIL rid_dropped_resp: got respcyc=%b respack=%b expected 0000/0", ifa.bot_respcyc, ifa.top_respack); end
        tick();
        ifa.top_respcyc = 1'b0;
        ifa.bot_respack = 4'b0000;
        ifa.bot_bid = 4'b0010;
        tick();
        vectors++; if (ifa.owner_valid !== 1'b1 || ifa.owner_id !== 2'd1) begin miscompares++; $display("[TB] FAIL rid_regrant: got valid=%b id=%0d expected 1/1", ifa.owner_valid, ifa.owner_id); end
        ifa.bot_bid = 4'b0000;
        tick();
        vectors++; if (ifa.owner_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rid_count_cleared: got valid=%b expected 0", ifa.owner_valid); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        clear_inputs();
        ifa.bot_req    = {64'hDDDD_0000_0000_0003, 64'hCCCC_0000_0000_0002, 64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0000};
        ifa.bot_reqtag = {13'h1333, 13'h1222, 13'h0111, 13'h0001};
        ifb.bot_req    = {64'h4444_0000_0000_0003, 64'h3333_0000_0000_0002, 64'h2222_0000_0000_0001, 64'h1111_0000_0000_0000};
        ifb.bot_reqtag = {13'h0444, 13'h0333, 13'h0222, 13'h0111};
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_drain();
        test_outstanding_cap();
        test_yield();
        test_reset_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
